wide_add_seq: RTL and testbench
===============================

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 Parameter W, default 16, SHALL set the width of the shared adder slice in bits.
REQ-002 Parameter WORDS, default 4, SHALL set the number of slices per operation; N = W*WORDS (default 64).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 start  input  1  SHALL request an operation; it is sampled only while ready=1.
REQ-006 a  input  N  SHALL be operand A, captured on accepted start.
REQ-007 b  input  N  SHALL be operand B, captured on accepted start.
REQ-008 cin  input  1  SHALL be the carry-in, captured on accepted start.
REQ-009 sub  input  1  SHALL select A-B when SUBTRACT_EN is defined; the port SHALL be absent otherwise.
REQ-010 ready  output  1  SHALL be high only in IDLE.
REQ-011 busy  output  1  SHALL be high only in RUN.
REQ-012 done  output  1  SHALL be a single-cycle pulse in DONE.
REQ-013 sum  output  N  SHALL be the result, held until the next accepted start.
REQ-014 cout  output  1  SHALL be the carry out of the top slice.
REQ-015 ovf  output  1  SHALL be the signed overflow: carry into the MSB XOR carry out of the MSB.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 Transitions SHALL be: IDLE->RUN on start; RUN->DONE after WORDS cycles; DONE->IDLE unconditionally.
REQ-018 An accepted start SHALL latch a, b, cin (and sub), clear the slice index to 0 and clear sum, cout and ovf.
REQ-019 In RUN cycle k (k=0..WORDS-1), one slice SHALL add A[kW+:W] + B'[kW+:W] + c and write sum[kW+:W].
REQ-020 In cycle 0, c SHALL be the latched cin; in cycle k>0, c SHALL be the carry registered from cycle k-1.
REQ-021 Latency from an accepted start to done=1 SHALL be exactly WORDS+1 cycles; throughput SHALL be one operation per WORDS+2 cycles.
REQ-022 start while not in IDLE, including during DONE, SHALL be ignored with no effect on state or outputs.
REQ-023 Changes to a, b, cin or sub after acceptance SHALL NOT affect the operation in flight.
REQ-024 cout and ovf SHALL be updated in the last RUN cycle and be valid together with done.
REQ-025 Arithmetic SHALL wrap modulo 2^N, with no saturation.

Reset
REQ-026 rst=1 at any clock edge, including mid-RUN or in DONE, SHALL force IDLE and abort any in-flight operation.
REQ-027 On reset, ready SHALL be 1, busy and done SHALL be 0, and sum, cout, ovf and the carry register SHALL be 0.
REQ-028 rst SHALL take priority over start in the same cycle.

Configuration
REQ-029 With SUBTRACT_EN defined and sub=1 latched, B' SHALL be ~B and the cycle-0 carry SHALL be 1, giving A-B with cin ignored; cout=1 SHALL mean no borrow.
REQ-030 With SUBTRACT_EN defined and sub=0, or with SUBTRACT_EN undefined, B' SHALL be B and the block SHALL add only.

Structure
REQ-031 Package wide_add_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default W and WORDS constants.
REQ-032 The W-bit combinational adder SHALL be a single carry-select sub-module, word_adder, instantiated exactly once and shared across all slices.

Verification
REQ-033 Carry chain: a=0x0000_0000_0000_FFFF, b=1, cin=0 -> sum=0x0000_0000_0001_0000, cout=0, ovf=0, done at cycle 5.
REQ-034 Full wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0.
REQ-035 Overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
REQ-036 Subtract (SUBTRACT_EN): a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0; a=7, b=5 -> sum=2, cout=1.
REQ-037 Protocol: start held high for 12 cycles with changing operands -> operations accepted only in IDLE; done pulses once per 6 cycles; each result matches the operands latched at its acceptance.
REQ-038 Reset mid-op: rst asserted in RUN cycle 2 -> next cycle ready=1, busy=0, sum=0, and no done pulse for the aborted operation.

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared types and default sizing for the sequential wide adder.
// Contents: FSM state encoding (IDLE/RUN/DONE), default slice width and
// slice count.
package wide_add_pkg;

  localparam int unsigned DEF_W     = 16;
  localparam int unsigned DEF_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/word_adder.sv
// W-bit carry-select adder slice, shared by every word of a wide operation.
// Ports:
//   a, b    : slice operands
//   cin     : carry into bit 0
//   sum_c   : slice sum
//   cout_c  : carry out of the MSB
//   cmsb_c  : carry into the MSB (for signed overflow detection)
// W must be at least 2.
module word_adder #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum_c,
  output logic         cout_c,
  output logic         cmsb_c
);

  localparam int unsigned LO  = W / 2;
  localparam int unsigned HI  = W - LO;
  localparam int unsigned LOW = LO + 1;
  localparam int unsigned HIW = HI + 1;

  logic [LO:0] lo_c;
  logic [HI:0] hi0_c;
  logic [HI:0] hi1_c;
  logic [HI:0] hi_c;

  // Lower half ripples; upper half is precomputed for both carry values.
  assign lo_c  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + LOW'(cin);
  assign hi0_c = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
  assign hi1_c = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]} + HIW'(1'b1);
  assign hi_c  = lo_c[LO] ? hi1_c : hi0_c;

  assign sum_c  = {hi_c[HI-1:0], lo_c[LO-1:0]};
  assign cout_c = hi_c[HI];
  // Carry into the MSB recovered from the MSB sum bit.
  assign cmsb_c = a[W-1] ^ b[W-1] ^ sum_c[W-1];

endmodule

// File: rtl/wide_add_seq.sv
// Sequential N-bit adder (N = W*WORDS) that reuses one W-bit slice adder over
// WORDS cycles, least-significant slice first.
// Optional feature: define SUBTRACT_EN to add the 'sub' port (A-B mode).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request; accepted only while ready
//   a, b, cin, (sub)  : operands, latched on accepted start
//   ready/busy/done   : IDLE / RUN / DONE state indicators (done is a pulse)
//   sum, cout, ovf    : result, carry out, signed overflow (held until next start)
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W*WORDS-1:0] a,
  input  logic [W*WORDS-1:0] b,
  input  logic               cin,
`ifdef SUBTRACT_EN
  input  logic               sub,
`endif
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [W*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int unsigned N    = W * WORDS;
  localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            cin_q, cin_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sub_eff;

`ifdef SUBTRACT_EN
  logic sub_q, sub_d;
  assign sub_eff = sub_q;
`else
  assign sub_eff = 1'b0;
`endif

  logic [W-1:0] a_sl, b_sl, bp_sl, s_sl;
  logic         c_sl, co_sl, cm_sl;

  // Select the operand slice addressed by the current word index.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IDXW'(k)) begin
        a_sl = a_q[k*W +: W];
        b_sl = b_q[k*W +: W];
      end
    end
    bp_sl = sub_eff ? ~b_sl : b_sl;
    // Word 0 takes the external carry (forced to 1 for subtraction).
    c_sl  = (idx_q == '0) ? (sub_eff | cin_q) : carry_q;
  end

  word_adder #(.W(W)) u_word_adder (
    .a      (a_sl),
    .b      (bp_sl),
    .cin    (c_sl),
    .sum_c  (s_sl),
    .cout_c (co_sl),
    .cmsb_c (cm_sl)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef SUBTRACT_EN
    sub_d   = sub_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          a_d     = a;
          b_d     = b;
          cin_d   = cin;
`ifdef SUBTRACT_EN
          sub_d   = sub;
`endif
          carry_d = 1'b0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        for (int k = 0; k < WORDS; k++) begin
          if (idx_q == IDXW'(k)) sum_d[k*W +: W] = s_sl;
        end
        carry_d = co_sl;
        if (idx_q == IDXW'(WORDS - 1)) begin
          cout_d  = co_sl;
          ovf_d   = cm_sl ^ co_sl;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUBTRACT_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUBTRACT_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (default W=16, WORDS=4).
// A cycle-level protocol model predicts ready/busy/done; expected results are
// pushed on acceptance and popped when done is due.
module tb_wide_add_seq;

  localparam int unsigned W     = 16;
  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = W * WORDS;
  localparam int unsigned NP1   = N + 1;

  typedef struct packed {
    logic [N-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, cin, sub;
  logic [N-1:0] a, b;
  logic         ready, busy, done, cout, ovf;
  logic [N-1:0] sum;

  always #5 clk = ~clk;

  wide_add_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SUBTRACT_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] aa, input logic [N-1:0] bb,
                                 input logic ci, input logic su);
    logic [N-1:0] bp;
    logic [N:0]   r;
    exp_t         e;
    bp   = su ? ~bb : bb;
    r    = {1'b0, aa} + {1'b0, bp} + NP1'(su ? 1'b1 : ci);
    e.s  = r[N-1:0];
    e.co = r[N];
    e.ov = (aa[N-1] == bp[N-1]) && (r[N-1] != aa[N-1]);
    return e;
  endfunction

  exp_t        sb[$];
  exp_t        held;
  exp_t        dir_e;
  bit          dir_v = 1'b0;
  int unsigned ph    = 0;

  // Protocol model + scoreboard, sampled on the falling edge.
  initial begin
    logic su;
    held = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("ready", N'(ready), N'(ph == 0));
      check("busy",  N'(busy),  N'(ph >= 1 && ph <= WORDS));
      check("done",  N'(done),  N'(ph == WORDS + 1));
      if (ph == 0 || ph == WORDS + 1) begin
        check("sum",  sum,      held.s);
        check("cout", N'(cout), N'(held.co));
        check("ovf",  N'(ovf),  N'(held.ov));
      end
`ifdef SUBTRACT_EN
      su = sub;
`else
      su = 1'b0;
`endif
      if (rst) begin
        ph   = 0;
        held = '0;
        sb.delete();
      end else if (ph == 0) begin
        if (start) begin
          sb.push_back(dir_v ? dir_e : model(a, b, cin, su));
          held = '0;
          ph   = 1;
        end
      end else if (ph < WORDS) begin
        ph++;
      end else if (ph == WORDS) begin
        if (sb.size() == 0) check("sb_underflow", N'(0), N'(1));
        else held = sb.pop_front();
        ph++;
      end else begin
        ph = 0;
      end
    end
  end

  task automatic scramble();
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // One complete operation; returns one cycle into the following IDLE.
  task automatic op(input logic [N-1:0] ta, input logic [N-1:0] tb_b, input logic tc,
                    input logic ts, input bit dv, input exp_t de);
    dir_v = dv;
    dir_e = de;
    a = ta; b = tb_b; cin = tc; sub = ts;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dir_v = 1'b0;
    scramble();
    repeat (WORDS + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, '{s: 64'h0000_0000_0001_0000, co: 1'b0, ov: 1'b0});
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b1, '{s: 64'h0, co: 1'b1, ov: 1'b0});
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, '{s: 64'h8000_0000_0000_0000, co: 1'b0, ov: 1'b1});
`ifdef SUBTRACT_EN
    op(64'd5, 64'd7, 1'b1, 1'b1, 1'b1, '{s: 64'hFFFF_FFFF_FFFF_FFFE, co: 1'b0, ov: 1'b0});
    op(64'd7, 64'd5, 1'b0, 1'b1, 1'b1, '{s: 64'd2, co: 1'b1, ov: 1'b0});
`endif

    // Random operations against the reference model
    for (int i = 0; i < 8; i++) begin
      op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0, '0);
    end

    // start held high with operands changing every cycle
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      scramble();
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (WORDS + 3) @(posedge clk);
    #1;

    // Reset during RUN cycle 2 aborts the operation
    scramble();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", N'(ready), N'(1));
    check("abort_busy",  N'(busy),  N'(0));
    check("abort_sum",   sum,       '0);
    repeat (WORDS + 3) @(posedge clk);
    #1;

    // Reset during DONE
    scramble();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (WORDS) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_done_sum", sum, '0);

    // Reset wins over start in the same cycle
    scramble();
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_start_ready", N'(ready), N'(1));
    @(posedge clk); #1;

    op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, '0);
    op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, '0);

    check("sb_empty", N'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
